// File: rtl/eth_stream_arbiter.sv
// Round-robin, burst-locked arbiter sharing one AXI-Stream egress among capture taps.
// A watchdog frees the egress when the owning tap stalls mid-burst.
module eth_stream_arbiter #(
   parameter int unsigned NUM_SRC    = 5,
   parameter int unsigned DATA_WIDTH = 128,
   parameter int unsigned TIMEOUT    = 1024,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_SRC-1:0]            src_valid,
   input  logic [NUM_SRC-1:0]            src_in_progress,
   input  logic [NUM_SRC-1:0]            src_last,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
   output logic [NUM_SRC-1:0]            src_ready,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic                          m_axis_tvalid,
   output logic                          m_axis_tlast,
   input  logic                          m_axis_tready,
   output logic [$clog2(NUM_SRC)-1:0]    grant_id,
   output logic                          busy,
   output logic                          timeout_pulse,
   output logic [CNT_WIDTH-1:0]          burst_count,
   output logic [CNT_WIDTH-1:0]          timeout_count
);

   localparam int unsigned   IW       = $clog2(NUM_SRC);
   localparam int unsigned   WW       = $clog2(TIMEOUT);
   localparam logic [WW-1:0] WDOG_MAX = WW'(TIMEOUT - 1);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SRC - 1);

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t                r_state;
   logic [NUM_SRC-1:0]    r_grant;
   logic [IW-1:0]         r_gidx;
   logic [IW-1:0]         r_rr_ptr;
   logic [WW-1:0]         r_wdog;
   logic [CNT_WIDTH-1:0]  r_burst_cnt;
   logic [CNT_WIDTH-1:0]  r_tmo_cnt;

   logic                  w_busy;
   logic                  w_valid_g;
   logic                  w_last_g;
   logic                  w_inprog_g;
   logic                  w_xfer;
   logic                  w_done;
   logic                  w_abandon;
   logic                  w_timeout;
   logic                  w_release;
   logic [DATA_WIDTH-1:0] w_data_g;
   logic [IW-1:0]         w_rr_next;
   logic                  w_arb_found;
   logic [IW-1:0]         w_arb_idx;
   logic [IW:0]           w_cand;
   logic [IW-1:0]         w_cand_idx;

   // Owner's signals selected by the one-hot grant; grant is zero while idle.
   assign w_busy     = (r_state == S_LOCKED);
   assign w_valid_g  = |(src_valid & r_grant);
   assign w_last_g   = |(src_last & r_grant);
   assign w_inprog_g = |(src_in_progress & r_grant);
   assign w_xfer     = w_valid_g & m_axis_tready;
   assign w_done     = w_xfer & w_last_g;
   assign w_abandon  = w_busy & ~w_inprog_g & ~w_valid_g;
   assign w_timeout  = w_busy & ~w_xfer & ~w_abandon & (r_wdog == WDOG_MAX);
   assign w_release  = w_done | w_abandon | w_timeout;
   assign w_rr_next  = (r_gidx == LAST_IDX) ? '0 : r_gidx + IW'(1);

   always_comb begin
      w_data_g = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (r_grant[i]) w_data_g = w_data_g | src_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // First requester at or after the round-robin pointer, wrapping past the last tap.
   always_comb begin
      w_arb_found = 1'b0;
      w_arb_idx   = '0;
      w_cand      = '0;
      w_cand_idx  = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         w_cand = {1'b0, r_rr_ptr} + (IW+1)'(k);
         if (w_cand >= (IW+1)'(NUM_SRC)) w_cand = w_cand - (IW+1)'(NUM_SRC);
         w_cand_idx = w_cand[IW-1:0];
         if (!w_arb_found && src_valid[w_cand_idx]) begin
            w_arb_found = 1'b1;
            w_arb_idx   = w_cand_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_grant     <= '0;
         r_gidx      <= '0;
         r_rr_ptr    <= '0;
         r_wdog      <= '0;
         r_burst_cnt <= '0;
         r_tmo_cnt   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_arb_found) begin
                  r_state <= S_LOCKED;
                  r_grant <= NUM_SRC'(1) << w_arb_idx;
                  r_gidx  <= w_arb_idx;
                  r_wdog  <= '0;
               end
            end
            S_LOCKED: begin
               if (w_release) begin
                  r_state  <= S_IDLE;
                  r_grant  <= '0;
                  r_rr_ptr <= w_rr_next;
                  r_wdog   <= '0;
               end else if (w_xfer) begin
                  r_wdog <= '0;
               end else begin
                  r_wdog <= r_wdog + WW'(1);
               end
               if (w_done && !(&r_burst_cnt)) r_burst_cnt <= r_burst_cnt + CNT_WIDTH'(1);
               if (w_timeout && !(&r_tmo_cnt)) r_tmo_cnt <= r_tmo_cnt + CNT_WIDTH'(1);
            end
            default: begin
               r_state <= S_IDLE;
               r_grant <= '0;
            end
         endcase
      end
   end

   assign src_ready     = r_grant & {NUM_SRC{m_axis_tready}};
   assign m_axis_tvalid = w_valid_g;
   assign m_axis_tdata  = w_valid_g ? w_data_g : '0;
   assign m_axis_tlast  = w_valid_g & w_last_g;
   assign grant_id      = r_gidx;
   assign busy          = w_busy;
   assign timeout_pulse = w_timeout;
   assign burst_count   = r_burst_cnt;
   assign timeout_count = r_tmo_cnt;

endmodule

// File: tb/tb_eth_stream_arbiter.sv
// Bench for eth_stream_arbiter: directed reset/burst/timeout scenarios, then random taps
// checked every cycle against a queue-free behavioural model of ownership and round-robin order.
module tb_eth_stream_arbiter;

   localparam int unsigned N    = 5;
   localparam int unsigned DW   = 128;
   localparam int unsigned TO   = 8;
   localparam int unsigned CW   = 4;
   localparam int unsigned IW   = $clog2(N);
   localparam int          MAXC = (1 << CW) - 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset;
   logic [N-1:0]    src_valid, src_in_progress, src_last, src_ready;
   logic [N*DW-1:0] src_data;
   logic [DW-1:0]   m_axis_tdata;
   logic            m_axis_tvalid, m_axis_tlast, m_axis_tready;
   logic [IW-1:0]   grant_id;
   logic            busy, timeout_pulse;
   logic [CW-1:0]   burst_count, timeout_count;

   eth_stream_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset),
      .src_valid(src_valid), .src_in_progress(src_in_progress), .src_last(src_last),
      .src_data(src_data), .src_ready(src_ready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
      .m_axis_tready(m_axis_tready), .grant_id(grant_id), .busy(busy),
      .timeout_pulse(timeout_pulse), .burst_count(burst_count), .timeout_count(timeout_count)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Model: owner is -1 when no tap holds the egress; idle_run counts stalled owned cycles.
   int m_owner = -1, m_rr = 0, m_idle_run = 0, m_bc = 0, m_tc = 0, m_raw_bc = 0;
   int m_xfer_tap;
   bit m_done, m_to, m_release;
   logic [N-1:0]  e_ready;
   logic          e_tvalid, e_tlast, e_pulse;
   logic [DW-1:0] e_tdata;

   int rem[N], seq[N], stall[N];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_eval();
      int g;
      bit aband;
      e_ready = '0; e_tvalid = 1'b0; e_tdata = '0; e_tlast = 1'b0; e_pulse = 1'b0;
      m_xfer_tap = -1; m_done = 0; m_to = 0; m_release = 0;
      if (m_owner >= 0) begin
         g = m_owner;
         if (m_axis_tready) e_ready[g] = 1'b1;
         e_tvalid = src_valid[g];
         e_tlast  = src_valid[g] & src_last[g];
         if (src_valid[g]) e_tdata = src_data[g*DW +: DW];
         if (src_valid[g] && m_axis_tready) m_xfer_tap = g;
         m_done    = (m_xfer_tap >= 0) && src_last[g];
         aband     = !src_in_progress[g] && !src_valid[g];
         m_to      = (m_xfer_tap < 0) && !aband && (m_idle_run + 1 == TO);
         e_pulse   = m_to;
         m_release = m_done || aband || m_to;
      end
   endtask

   task automatic model_advance();
      model_eval();
      if (reset) begin
         m_owner = -1; m_rr = 0; m_idle_run = 0; m_bc = 0; m_tc = 0; m_raw_bc = 0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            if (m_owner < 0 && src_valid[(m_rr + k) % N]) begin
               m_owner    = (m_rr + k) % N;
               m_idle_run = 0;
            end
         end
      end else begin
         if (m_done) m_raw_bc++;
         if (m_done && m_bc < MAXC) m_bc++;
         if (m_to && m_tc < MAXC) m_tc++;
         if (m_release) begin
            m_rr       = (m_owner + 1) % N;
            m_owner    = -1;
            m_idle_run = 0;
         end else begin
            m_idle_run = (m_xfer_tap >= 0) ? 0 : m_idle_run + 1;
         end
      end
   endtask

   task automatic compare();
      chk("src_ready", DW'(src_ready), DW'(e_ready));
      chk("tvalid", DW'(m_axis_tvalid), DW'(e_tvalid));
      chk("tdata", m_axis_tdata, e_tdata);
      chk("tlast", DW'(m_axis_tlast), DW'(e_tlast));
      chk("busy", DW'(busy), DW'(m_owner >= 0));
      if (m_owner >= 0) chk("grant_id", DW'(grant_id), DW'(m_owner));
      chk("timeout_pulse", DW'(timeout_pulse), DW'(e_pulse));
      chk("burst_count", DW'(burst_count), DW'(m_bc));
      chk("timeout_count", DW'(timeout_count), DW'(m_tc));
   endtask

   task automatic settle();
      #2;
      model_eval();
      if (!reset) compare();
   endtask

   task automatic tick();
      @(posedge clk);
      model_advance();
      #1;
   endtask

   task automatic clear_inputs();
      src_valid = '0; src_in_progress = '0; src_last = '0; src_data = '0; m_axis_tready = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_inputs();
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic drive_random();
      logic [N-1:0]    v, p, l;
      logic [N*DW-1:0] d;
      v = '0; p = '0; l = '0; d = '0;
      for (int i = 0; i < N; i++) begin
         if (rem[i] == 0 && $urandom_range(3) == 0) begin
            rem[i]   = 1 + int'($urandom_range(3));
            stall[i] = 0;
         end else if (rem[i] > 0 && $urandom_range(59) == 0) begin
            rem[i] = 0;
         end
         if (rem[i] > 0 && stall[i] == 0 && $urandom_range(39) == 0)
            stall[i] = 4 + int'($urandom_range(7));
         if (rem[i] > 0) begin
            v[i] = (stall[i] == 0) && ($urandom_range(3) != 0);
            p[i] = ($urandom_range(9) != 0);
            l[i] = (rem[i] == 1);
            d[i*DW +: DW] = {32'(i), 32'(seq[i]), $urandom, $urandom};
         end
      end
      src_valid = v; src_in_progress = p; src_last = l; src_data = d;
      m_axis_tready = ($urandom_range(3) != 0);
   endtask

   initial begin
      // Reset held with every tap requesting: everything stays quiet.
      reset = 1'b1;
      clear_inputs();
      src_valid = '1; src_in_progress = '1; m_axis_tready = 1'b1;
      for (int r = 0; r < 3; r++) begin
         tick();
         #2;
         chk("rst_ready", DW'(src_ready), '0);
         chk("rst_tvalid", DW'(m_axis_tvalid), '0);
         chk("rst_tdata", m_axis_tdata, '0);
         chk("rst_busy", DW'(busy), '0);
         chk("rst_grant_id", DW'(grant_id), '0);
         chk("rst_pulse", DW'(timeout_pulse), '0);
         chk("rst_bcount", DW'(burst_count), '0);
         chk("rst_tcount", DW'(timeout_count), '0);
      end
      reset = 1'b0;
      clear_inputs();
      tick();

      // Tap 2 alone, 4-beat burst with egress always ready.
      for (int c = 0; c <= 5; c++) begin
         clear_inputs();
         m_axis_tready = 1'b1;
         if (c <= 4) begin
            src_valid[2] = 1'b1;
            src_in_progress[2] = 1'b1;
            src_data[2*DW +: DW] = DW'(32'hB0 + ((c == 0) ? 0 : c - 1));
            src_last[2] = (c == 4);
         end
         settle();
         if (c == 1) chk("t2_ready_c1", DW'(src_ready), DW'(5'b00100));
         if (c == 4) chk("t2_tlast_c4", DW'(m_axis_tlast), DW'(1'b1));
         if (c == 5) begin
            chk("t2_idle_after", DW'(busy), '0);
            chk("t2_bcount", DW'(burst_count), DW'(1));
         end
         tick();
      end

      // Tap 4 stalls after grant; tap 0 waits and wins once the watchdog fires.
      do_reset();
      for (int c = 0; c <= 11; c++) begin
         clear_inputs();
         m_axis_tready = (c >= 10);
         if (c == 0) begin
            src_valid[4] = 1'b1;
         end else begin
            src_valid[0] = (c <= 10);
            src_in_progress[0] = (c <= 10);
            src_last[0] = 1'b1;
            src_data[0 +: DW] = DW'(32'hA0);
         end
         src_in_progress[4] = 1'b1;
         settle();
         if (c >= 1 && c <= 8) chk("t5_pulse", DW'(timeout_pulse), DW'(c == 8));
         if (c == 1) chk("t5_gid4", DW'(grant_id), DW'(4));
         if (c == 9) begin
            chk("t5_idle", DW'(busy), '0);
            chk("t5_tcount", DW'(timeout_count), DW'(1));
         end
         if (c == 10) begin
            chk("t5_gid0", DW'(grant_id), DW'(0));
            chk("t5_tdata", m_axis_tdata, DW'(32'hA0));
         end
         if (c == 11) chk("t5_bcount", DW'(burst_count), DW'(1));
         tick();
      end

      // Random taps with stalls, abandons and egress backpressure; one reset mid-run.
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         reset = (cyc == 500 || cyc == 501);
         drive_random();
         settle();
         tick();
         if (!reset && m_xfer_tap >= 0) begin
            rem[m_xfer_tap]--;
            seq[m_xfer_tap]++;
         end
         for (int i = 0; i < N; i++) if (stall[i] > 0) stall[i]--;
      end
      reset = 1'b0;
      clear_inputs();
      settle();
      if (m_raw_bc >= MAXC) chk("bcount_saturated", DW'(burst_count), DW'(4'hF));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
